// File: rtl/alu_exec_unit_if.sv
// Opcode encodings shared by the issue side and the execution unit, plus the
// RS->ALU issue / ALU->CDB result interface bundle.
// Ports: master = reservation station / CDB side, slave = alu_exec_unit.
package alu_exec_pkg;
    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_ADD   = 6'd11;
    localparam logic [5:0] OP_SUB   = 6'd12;
    localparam logic [5:0] OP_SLL   = 6'd13;
    localparam logic [5:0] OP_SLT   = 6'd14;
    localparam logic [5:0] OP_SLTU  = 6'd15;
    localparam logic [5:0] OP_XOR   = 6'd16;
    localparam logic [5:0] OP_SRL   = 6'd17;
    localparam logic [5:0] OP_SRA   = 6'd18;
    localparam logic [5:0] OP_OR    = 6'd19;
    localparam logic [5:0] OP_AND   = 6'd20;
    localparam logic [5:0] OP_ADDI  = 6'd21;
    localparam logic [5:0] OP_SLTI  = 6'd22;
    localparam logic [5:0] OP_SLTIU = 6'd23;
    localparam logic [5:0] OP_XORI  = 6'd24;
    localparam logic [5:0] OP_ORI   = 6'd25;
    localparam logic [5:0] OP_ANDI  = 6'd26;
    localparam logic [5:0] OP_SLLI  = 6'd27;
    localparam logic [5:0] OP_SRLI  = 6'd28;
    localparam logic [5:0] OP_SRAI  = 6'd29;
endpackage

interface alu_exec_unit_if #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int ADDR_W = 32
);
    // global control
    logic              rdy;
    logic              clr;
    // issue side
    logic              alu_enable;
    logic [OP_W-1:0]   to_alu_op;
    logic [DATA_W-1:0] to_alu_rs1_value;
    logic [DATA_W-1:0] to_alu_rs2_value;
    logic [DATA_W-1:0] to_alu_imm;
    logic [ADDR_W-1:0] to_alu_pc;
    logic [ROB_W-1:0]  to_alu_rd_rename;
    logic              alu_full;
    // CDB side
    logic              alu_broadcast;
    logic [DATA_W-1:0] alu_cbd_value;
    logic [ROB_W-1:0]  alu_update_rename;
    logic              alu_jump;
    logic [ADDR_W-1:0] alu_target;
    logic              cdb_grant;

    modport master (
        output rdy, clr, alu_enable, to_alu_op, to_alu_rs1_value, to_alu_rs2_value,
               to_alu_imm, to_alu_pc, to_alu_rd_rename, cdb_grant,
        input  alu_full, alu_broadcast, alu_cbd_value, alu_update_rename, alu_jump, alu_target
    );

    modport slave (
        input  rdy, clr, alu_enable, to_alu_op, to_alu_rs1_value, to_alu_rs2_value,
               to_alu_imm, to_alu_pc, to_alu_rd_rename, cdb_grant,
        output alu_full, alu_broadcast, alu_cbd_value, alu_update_rename, alu_jump, alu_target
    );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32I integer/branch/jump execution unit feeding a small result queue onto the ALU CDB slot.
// Latency: op issued at edge N is visible on the CDB outputs right after edge N.
// Backpressure: alu_full stops RS issue; head entry holds until cdb_grant pops it.
// Ports: clk_i, rst_ni (async, active-low), bus_if (slave): issue bus in, CDB result out.
module alu_exec_unit #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int ADDR_W = 32,
    parameter int QDEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    alu_exec_unit_if.slave  bus_if
);
    import alu_exec_pkg::*;

    localparam int PTR_W = $clog2(QDEPTH);

    // ---------------- combinational execute ----------------
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_plus_imm;
    logic              is_imm;
    logic [DATA_W-1:0] res_value;
    logic              res_jump;
    logic [ADDR_W-1:0] res_target;

    assign opa         = bus_if.to_alu_rs1_value;
    assign pc_plus4    = bus_if.to_alu_pc + ADDR_W'(4);
    assign pc_plus_imm = bus_if.to_alu_pc + ADDR_W'(bus_if.to_alu_imm);
    assign is_imm      = (bus_if.to_alu_op >= OP_ADDI) && (bus_if.to_alu_op <= OP_SRAI);
    assign opb         = is_imm ? bus_if.to_alu_imm : bus_if.to_alu_rs2_value;

    always_comb begin
        res_value  = '0;
        res_jump   = 1'b0;
        res_target = pc_plus4;
        case (bus_if.to_alu_op)
            OP_LUI:            res_value = bus_if.to_alu_imm;
            OP_AUIPC:          res_value = DATA_W'(pc_plus_imm);
            OP_JAL: begin
                res_value  = DATA_W'(pc_plus4);
                res_jump   = 1'b1;
                res_target = pc_plus_imm;
            end
            OP_JALR: begin
                res_value  = DATA_W'(pc_plus4);
                res_jump   = 1'b1;
                res_target = ADDR_W'(opa + bus_if.to_alu_imm) & ~ADDR_W'(1);
            end
            // branches compare rs1 against rs2 (opb is rs2 for these ops)
            OP_BEQ:            res_jump = (opa == opb);
            OP_BNE:            res_jump = (opa != opb);
            OP_BLT:            res_jump = ($signed(opa) <  $signed(opb));
            OP_BGE:            res_jump = ($signed(opa) >= $signed(opb));
            OP_BLTU:           res_jump = (opa <  opb);
            OP_BGEU:           res_jump = (opa >= opb);
            OP_ADD,  OP_ADDI:  res_value = opa + opb;
            OP_SUB:            res_value = opa - opb;
            OP_SLL,  OP_SLLI:  res_value = opa << opb[4:0];
            OP_SLT,  OP_SLTI:  res_value = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
            OP_SLTU, OP_SLTIU: res_value = {{(DATA_W-1){1'b0}}, (opa < opb)};
            OP_XOR,  OP_XORI:  res_value = opa ^ opb;
            OP_SRL,  OP_SRLI:  res_value = opa >> opb[4:0];
            OP_SRA,  OP_SRAI:  res_value = DATA_W'($signed(opa) >>> opb[4:0]);
            OP_OR,   OP_ORI:   res_value = opa | opb;
            OP_AND,  OP_ANDI:  res_value = opa & opb;
            default:           res_value = '0;
        endcase
        // a branch that is not taken falls through
        if ((bus_if.to_alu_op >= OP_BEQ) && (bus_if.to_alu_op <= OP_BGEU)) begin
            res_target = res_jump ? pc_plus_imm : pc_plus4;
        end
    end

    // ---------------- result queue ----------------
    logic [DATA_W-1:0] val_q [QDEPTH];
    logic [ROB_W-1:0]  ren_q [QDEPTH];
    logic              jmp_q [QDEPTH];
    logic [ADDR_W-1:0] tgt_q [QDEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    cnt_q,    cnt_d;

    logic full;
    logic nonempty;
    logic push;
    logic pop;

    assign full     = (cnt_q == (PTR_W+1)'(QDEPTH));
    assign nonempty = (cnt_q != '0);

    // pop is evaluated first so a full queue can still accept an op on the edge it drains one
    assign pop  = bus_if.rdy && !bus_if.clr && nonempty && bus_if.cdb_grant;
    assign push = bus_if.rdy && !bus_if.clr && bus_if.alu_enable && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (bus_if.rdy) begin
            if (bus_if.clr) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
            end else begin
                if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                cnt_d = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                val_q[i] <= '0;
                ren_q[i] <= '0;
                jmp_q[i] <= 1'b0;
                tgt_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) begin
                val_q[wr_ptr_q] <= res_value;
                ren_q[wr_ptr_q] <= bus_if.to_alu_rd_rename;
                jmp_q[wr_ptr_q] <= res_jump;
                tgt_q[wr_ptr_q] <= res_target;
            end
        end
    end

    // Head fields are forced to zero while empty so stale popped entries never leak onto the CDB.
    assign bus_if.alu_full          = full;
    assign bus_if.alu_broadcast     = nonempty;
    assign bus_if.alu_cbd_value     = nonempty ? val_q[rd_ptr_q] : '0;
    assign bus_if.alu_update_rename = nonempty ? ren_q[rd_ptr_q] : '0;
    assign bus_if.alu_jump          = nonempty ? jmp_q[rd_ptr_q] : 1'b0;
    assign bus_if.alu_target        = nonempty ? tgt_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios plus randomized issue/grant/flush traffic,
// compared against a queue-based reference model of the result FIFO.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    localparam int QDEPTH = 2;

    typedef struct {
        logic [31:0] value;
        logic [3:0]  rename;
        logic        jump;
        logic [31:0] target;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   viol   = 0;
    res_t mq[$];

    alu_exec_unit_if bus();

    alu_exec_unit dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RS protocol violations as seen from the DUT's own full flag
    always @(posedge clk) begin
        if (rst_n && bus.rdy && !bus.clr && bus.alu_enable && bus.alu_full &&
            !(bus.cdb_grant && bus.alu_broadcast))
            viol++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Reference semantics of one op, straight from the ISA rules.
    function automatic res_t ref_exec(input logic [5:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] imm,
                                      input logic [31:0] pc, input logic [3:0] tag);
        res_t r;
        int   sa, sb, si;
        logic [31:0] bb;
        bit   is_br;
        r.value  = 0;
        r.rename = tag;
        r.jump   = 0;
        r.target = pc + 4;
        bb = (op >= OP_ADDI && op <= OP_SRAI) ? imm : b;
        sa = a;
        sb = bb;
        si = 0;
        is_br = 0;
        case (op)
            OP_LUI:   r.value = imm;
            OP_AUIPC: r.value = pc + imm;
            OP_JAL:   begin r.value = pc + 4; r.jump = 1; r.target = pc + imm; end
            OP_JALR:  begin r.value = pc + 4; r.jump = 1; r.target = (a + imm) & 32'hFFFF_FFFE; end
            OP_BEQ:   begin is_br = 1; r.jump = (a == b); end
            OP_BNE:   begin is_br = 1; r.jump = (a != b); end
            OP_BLT:   begin is_br = 1; r.jump = (sa < sb); end
            OP_BGE:   begin is_br = 1; r.jump = !(sa < sb); end
            OP_BLTU:  begin is_br = 1; r.jump = (a < b); end
            OP_BGEU:  begin is_br = 1; r.jump = !(a < b); end
            OP_ADD, OP_ADDI:   r.value = a + bb;
            OP_SUB:            r.value = a - bb;
            OP_SLL, OP_SLLI:   r.value = a << (bb % 32);
            OP_SLT, OP_SLTI:   r.value = (sa < sb) ? 1 : 0;
            OP_SLTU, OP_SLTIU: r.value = (a < bb) ? 1 : 0;
            OP_XOR, OP_XORI:   r.value = a ^ bb;
            OP_SRL, OP_SRLI:   r.value = a >> (bb % 32);
            OP_SRA, OP_SRAI:   begin si = sa >>> (bb % 32); r.value = si; end
            OP_OR, OP_ORI:     r.value = a | bb;
            OP_AND, OP_ANDI:   r.value = a & bb;
            default:           r.value = 0;
        endcase
        if (is_br && r.jump) r.target = pc + imm;
        return r;
    endfunction

    task automatic drive_idle();
        bus.rdy = 1; bus.clr = 0; bus.alu_enable = 0; bus.cdb_grant = 0;
        bus.to_alu_op = OP_NOP; bus.to_alu_rs1_value = 0; bus.to_alu_rs2_value = 0;
        bus.to_alu_imm = 0; bus.to_alu_pc = 0; bus.to_alu_rd_rename = 0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        bus.alu_enable = 1; bus.to_alu_op = op; bus.to_alu_rs1_value = a;
        bus.to_alu_rs2_value = b; bus.to_alu_imm = imm; bus.to_alu_pc = pc;
        bus.to_alu_rd_rename = tag;
    endtask

    // Advance one clock; update the model with what the driven inputs should do at that edge.
    task automatic step();
        int   sz;
        bit   pop, push;
        res_t r;
        sz   = mq.size();
        pop  = bus.rdy && !bus.clr && sz > 0 && bus.cdb_grant;
        push = bus.rdy && !bus.clr && bus.alu_enable && (sz < QDEPTH || pop);
        r = ref_exec(bus.to_alu_op, bus.to_alu_rs1_value, bus.to_alu_rs2_value,
                     bus.to_alu_imm, bus.to_alu_pc, bus.to_alu_rd_rename);
        @(posedge clk);
        #1;
        if (bus.rdy) begin
            if (bus.clr) mq.delete();
            else begin
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back(r);
            end
        end
    endtask

    task automatic check_out(input string tag);
        res_t e;
        e = '{value: 0, rename: 0, jump: 0, target: 0};
        if (mq.size() > 0) e = mq[0];
        chk({tag, ".bcast"},  bus.alu_broadcast, mq.size() != 0);
        chk({tag, ".full"},   bus.alu_full,      mq.size() == QDEPTH);
        chk({tag, ".value"},  bus.alu_cbd_value, e.value);
        chk({tag, ".rename"}, bus.alu_update_rename, e.rename);
        chk({tag, ".jump"},   bus.alu_jump,      e.jump);
        chk({tag, ".target"}, bus.alu_target,    e.target);
    endtask

    logic [5:0] ops [30];

    initial begin
        for (int i = 0; i < 29; i++) ops[i] = 6'(i + 1);
        ops[29] = 6'd63;  // unknown opcode
        drive_idle();
        rst_n = 0;
        #12;
        check_out("reset");
        @(negedge clk);
        rst_n = 1;

        // 1: ADD 7 + -3, tag 5, grant held high
        bus.cdb_grant = 1;
        issue(OP_ADD, 7, 32'hFFFF_FFFD, 0, 32'h10, 5);
        step();
        chk("t1.value", bus.alu_cbd_value, 4);
        chk("t1.rename", bus.alu_update_rename, 5);
        check_out("t1");
        bus.alu_enable = 0;
        step();
        chk("t1.popped", bus.alu_broadcast, 0);

        // 2: BLT taken, then BLTU not taken on the same operands
        bus.cdb_grant = 0;
        issue(OP_BLT, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 1);
        step();
        chk("t2.blt.jump", bus.alu_jump, 1);
        chk("t2.blt.target", bus.alu_target, 32'h120);
        bus.cdb_grant = 1;
        issue(OP_BLTU, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 2);
        step();
        chk("t2.bltu.jump", bus.alu_jump, 0);
        chk("t2.bltu.target", bus.alu_target, 32'h104);
        check_out("t2");
        bus.alu_enable = 0;
        step();

        // 3: JALR clears bit 0 of the target
        bus.cdb_grant = 0;
        issue(OP_JALR, 32'h1003, 0, 4, 32'h40, 3);
        step();
        chk("t3.value", bus.alu_cbd_value, 32'h44);
        chk("t3.target", bus.alu_target, 32'h1006);
        chk("t3.jump", bus.alu_jump, 1);
        bus.alu_enable = 0; bus.cdb_grant = 1;
        step();

        // 4: fill, overflow drop, then push+pop while full
        bus.cdb_grant = 0;
        issue(OP_ADDI, 1, 0, 1, 0, 1); step();
        issue(OP_ADDI, 2, 0, 2, 0, 2); step();
        chk("t4.full", bus.alu_full, 1);
        issue(OP_ADDI, 3, 0, 3, 0, 3); step();
        chk("t4.viol", viol, 1);
        chk("t4.head_after_drop", bus.alu_update_rename, 1);
        check_out("t4.drop");
        bus.cdb_grant = 1;
        issue(OP_ADDI, 4, 0, 4, 0, 4); step();
        chk("t4.full_kept", bus.alu_full, 1);
        chk("t4.head2", bus.alu_update_rename, 2);
        bus.alu_enable = 0; step();
        chk("t4.head4", bus.alu_update_rename, 4);
        chk("t4.val4", bus.alu_cbd_value, 8);
        step();
        check_out("t4.empty");

        // 5: flush with two queued and a concurrent issue
        bus.cdb_grant = 0;
        issue(OP_XOR, 5, 6, 0, 0, 5); step();
        issue(OP_OR,  5, 6, 0, 0, 6); step();
        issue(OP_AND, 5, 6, 0, 0, 7); bus.clr = 1; step();
        bus.clr = 0; bus.alu_enable = 0;
        chk("t5.bcast", bus.alu_broadcast, 0);
        chk("t5.full", bus.alu_full, 0);
        bus.cdb_grant = 1; step();
        chk("t5.still_empty", bus.alu_broadcast, 0);

        // 6: async reset mid-broadcast, then rdy freeze
        bus.cdb_grant = 0;
        issue(OP_LUI, 0, 0, 32'hABCD_E000, 0, 9); step();
        bus.alu_enable = 0;
        #3 rst_n = 0;
        #1;
        mq.delete();
        check_out("t6.async_rst");
        @(negedge clk);
        rst_n = 1;
        issue(OP_AUIPC, 0, 0, 32'h1000, 32'h200, 10); step();
        bus.alu_enable = 0; bus.rdy = 0; bus.cdb_grant = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("t6.frozen");
        end
        chk("t6.held", bus.alu_cbd_value, 32'h1200);
        bus.rdy = 1; step();
        check_out("t6.popped");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.rdy       = ($urandom_range(0, 7) != 0);
            bus.clr       = ($urandom_range(0, 24) == 0);
            bus.cdb_grant = $urandom_range(0, 1);
            issue(ops[$urandom_range(0, 29)], $urandom, $urandom, $urandom, $urandom,
                  4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                bus.to_alu_rs2_value = bus.to_alu_rs1_value;  // exercise equal-operand branches
            end
            bus.alu_enable = $urandom_range(0, 1);
            if (mq.size() == QDEPTH && !bus.cdb_grant) bus.alu_enable = 0;
            step();
            check_out("rand");
        end
        chk("viol.final", viol, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
